// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
// Mode encoding and the split point between the two XOR stages.
package gray_conv_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } conv_mode_e;

  function automatic int split_h(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/gray_prefix_xor.sv
// Suffix-XOR over N bits seeded by a carry-in bit.
// o_data[i] = i_cin ^ XOR(i_data[N-1:i]).
module gray_prefix_xor #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_data,
  input  logic         i_cin,
  output logic [N-1:0] o_data
);

  logic w_acc;

  always_comb begin
    w_acc  = i_cin;
    o_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_acc     = w_acc ^ i_data[i];
      o_data[i] = w_acc;
    end
  end

endmodule

// File: rtl/gray_conv_pipe.sv
// Two-stage Gray<->binary converter with per-beat mode and
// valid/ready flow control; G2B XOR chain is split across stages.
import gray_conv_pkg::*;

module gray_conv_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  localparam int H  = split_h(WIDTH);
  localparam int UW = WIDTH - H;

  conv_mode_e       w_in_mode;
  logic [UW-1:0]    w_up;
  logic [H-1:0]     w_lo;
  logic [WIDTH-1:0] w_s1_next;
  logic [WIDTH-1:0] w_s2_next;
  logic             w_s1_ready;
  logic             w_s2_ready;

  conv_mode_e       r_s1_mode;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_valid;
  conv_mode_e       r_s2_mode;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_s2_valid;

  assign w_in_mode  = conv_mode_e'(in_mode);
  assign w_s2_ready = !r_s2_valid | out_ready;
  assign w_s1_ready = !r_s1_valid | w_s2_ready;
  assign in_ready   = w_s1_ready;

  gray_prefix_xor #(.N(UW)) u_up (
    .i_data (in_data[WIDTH-1:H]),
    .i_cin  (1'b0),
    .o_data (w_up)
  );

  // Lower half continues the chain from the resolved b[H]
  gray_prefix_xor #(.N(H)) u_lo (
    .i_data (r_s1_data[H-1:0]),
    .i_cin  (r_s1_data[H]),
    .o_data (w_lo)
  );

  always_comb begin
    w_s1_next = '0;
    unique case (w_in_mode)
      MODE_B2G: w_s1_next = in_data ^ (in_data >> 1);
      MODE_G2B: w_s1_next = {w_up, in_data[H-1:0]};
    endcase
  end

  always_comb begin
    w_s2_next = '0;
    unique case (r_s1_mode)
      MODE_B2G: w_s2_next = r_s1_data;
      MODE_G2B: w_s2_next = {r_s1_data[WIDTH-1:H], w_lo};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_G2B;
      r_s1_data  <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= w_in_mode;
        r_s1_data <= w_s1_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= MODE_G2B;
      r_s2_data  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_data <= w_s2_next;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_mode  = r_s2_mode;

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed and random checks of gray_conv_pipe at widths 8,3,2,7,16.
// Scoreboards compare against a bit-serial reference model.
module tb_gray_conv_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic v8 = 0, m8 = 0, or8 = 0, ir8, ov8, om8;
  logic [7:0] d8 = '0, od8;
  logic v3 = 0, m3 = 0, or3 = 0, ir3, ov3, om3;
  logic [2:0] d3 = '0, od3;
  logic v2 = 0, m2 = 0, or2 = 0, ir2, ov2, om2;
  logic [1:0] d2 = '0, od2;
  logic v7 = 0, m7 = 0, or7 = 0, ir7, ov7, om7;
  logic [6:0] d7 = '0, od7;
  logic v16 = 0, m16 = 0, or16 = 0, ir16, ov16, om16;
  logic [15:0] d16 = '0, od16;

  gray_conv_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(ir8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8));
  gray_conv_pipe #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(ir3), .in_data(d3), .in_mode(m3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_mode(om3));
  gray_conv_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(ir2), .in_data(d2), .in_mode(m2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_mode(om2));
  gray_conv_pipe #(.WIDTH(7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v7), .in_ready(ir7), .in_data(d7), .in_mode(m7),
    .out_valid(ov7), .out_ready(or7), .out_data(od7), .out_mode(om7));
  gray_conv_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(ir16), .in_data(d16), .in_mode(m16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_mode(om16));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_conv(input logic m,
                                           input logic [63:0] x,
                                           input int w);
    logic [63:0] r;
    r = '0;
    if (m) r = x ^ (x >> 1);
    else begin
      r[w-1] = x[w-1];
      for (int i = w - 2; i >= 0; i--) r[i] = r[i+1] ^ x[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // WIDTH=8 output monitor: {mode,data} and cycle of each transfer
  logic [8:0] q8[$];
  int t8[$];
  always @(negedge clk)
    if (ov8 && or8) begin
      q8.push_back({om8, od8});
      t8.push_back(cyc);
    end

  function automatic logic [8:0] pop8();
    if (q8.size() == 0) return 'x;
    return q8.pop_front();
  endfunction

  function automatic int popt8();
    if (t8.size() == 0) return -100;
    return t8.pop_front();
  endfunction

  task automatic send8(input logic m, input logic [7:0] d);
    logic acc;
    int n;
    m8 = m; d8 = d; v8 = 1'b1; n = 0;
    do begin
      @(negedge clk);
      acc = ir8;
      tick();
      n++;
    end while (!acc && n < 20);
    chk("send8_accept", acc, 1);
  endtask

  // WIDTH=7 scoreboard
  logic [64:0] exp7[$];
  logic [64:0] e7;
  int n_out7 = 0;
  always @(negedge clk) begin
    if (v7 && ir7) exp7.push_back({m7, ref_conv(m7, 64'(d7), 7)});
    if (ov7 && or7) begin
      n_out7++;
      chk("w7_sb_nonempty", exp7.size() > 0, 1);
      if (exp7.size() > 0) begin
        e7 = exp7.pop_front();
        chk("w7_data", 64'(od7), e7[63:0]);
        chk("w7_mode", om7, e7[64]);
      end
    end
  end

  // WIDTH=16 scoreboard plus stall-stability and no-bubble checks
  logic [64:0] exp16[$];
  logic [64:0] e16;
  logic p_stall = 0;
  logic [16:0] p_out = '0;
  always @(negedge clk) begin
    if (v16 && ir16) exp16.push_back({m16, ref_conv(m16, 64'(d16), 16)});
    if (ov16 && or16) begin
      chk("w16_sb_nonempty", exp16.size() > 0, 1);
      if (exp16.size() > 0) begin
        e16 = exp16.pop_front();
        chk("w16_data", 64'(od16), e16[63:0]);
        chk("w16_mode", om16, e16[64]);
      end
    end
    if (p_stall) chk("w16_stable", {ov16, om16, od16}, {1'b1, p_out});
    if (or16) chk("w16_nobubble", ir16, 1);
    p_stall = ov16 && !or16;
    p_out = {om16, od16};
  end

  logic [7:0] bp_d[4] = '{8'h01, 8'h03, 8'h0F, 8'hF0};
  logic bp_m[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [8:0] bp_e[4] = '{{1'b0, 8'h01}, {1'b1, 8'h02},
                          {1'b0, 8'h0A}, {1'b1, 8'h88}};

  initial begin
    logic acc;
    logic hold;
    logic [7:0] snap;
    int idx;
    int n;
    int t0, t1, t2;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_during", ir8, 1);
    chk("rst_out_valid_during", ov8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", ov8, 0);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_data", od8, 0);
    chk("rst_out_mode", om8, 0);

    // Single beat latency
    tick();
    or8 = 1; m8 = 0; d8 = 8'hC5; v8 = 1;
    @(negedge clk);
    chk("lat_in_ready", ir8, 1);
    tick();
    v8 = 0;
    @(negedge clk);
    chk("lat_not_early", ov8, 0);
    tick();
    @(negedge clk);
    chk("lat_valid", ov8, 1);
    chk("lat_data_c5", od8, 8'h86);
    chk("lat_mode", om8, 0);
    tick();
    q8.delete(); t8.delete();

    // Round trip B2G
    send8(1'b1, 8'h86);
    v8 = 0;
    repeat (3) tick();
    chk("rt_count", q8.size(), 1);
    chk("rt_b2g_86", pop8(), {1'b1, 8'hC5});

    // Back-to-back mixed modes
    q8.delete(); t8.delete();
    send8(1'b0, 8'hFF);
    send8(1'b1, 8'hFF);
    send8(1'b0, 8'hFF);
    v8 = 0;
    repeat (4) tick();
    chk("b2b_count", q8.size(), 3);
    chk("b2b_0", pop8(), {1'b0, 8'hAA});
    chk("b2b_1", pop8(), {1'b1, 8'h80});
    chk("b2b_2", pop8(), {1'b0, 8'hAA});
    t0 = popt8(); t1 = popt8(); t2 = popt8();
    chk("b2b_gap01", t1 - t0, 1);
    chk("b2b_gap12", t2 - t1, 1);

    // Backpressure: only two beats fit
    q8.delete(); t8.delete();
    or8 = 0; idx = 0; snap = '0;
    for (int c = 0; c < 6; c++) begin
      m8 = bp_m[idx & 3]; d8 = bp_d[idx & 3]; v8 = 1;
      @(negedge clk);
      acc = ir8;
      if (c == 3) snap = od8;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    @(negedge clk);
    chk("bp_in_ready_low", ir8, 0);
    chk("bp_out_valid", ov8, 1);
    chk("bp_hold", od8, snap);
    chk("bp_head", od8, 8'h01);
    tick();
    or8 = 1; n = 0;
    while (idx < 4 && n < 20) begin
      m8 = bp_m[idx & 3]; d8 = bp_d[idx & 3]; v8 = 1;
      @(negedge clk);
      acc = ir8;
      tick();
      if (acc) idx++;
      n++;
    end
    v8 = 0;
    chk("bp_all_in", idx, 4);
    repeat (4) tick();
    chk("bp_out_count", q8.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_out%0d", i), pop8(), bp_e[i]);

    // Small widths
    or3 = 1; or2 = 1;
    v3 = 1; m3 = 0; d3 = 3'b111;
    v2 = 1; m2 = 0; d2 = 2'b11;
    tick();
    m3 = 1; d3 = 3'b101;
    v2 = 0;
    tick();
    v3 = 0;
    @(negedge clk);
    chk("w3_g2b_111", od3, 3'b101);
    chk("w3_g2b_mode", om3, 0);
    chk("w2_g2b_11", od2, 2'b10);
    chk("w2_valid", ov2, 1);
    tick();
    @(negedge clk);
    chk("w3_b2g_101", od3, 3'b111);
    chk("w3_b2g_mode", om3, 1);
    tick();

    // WIDTH=7 exhaustive sweep, both modes
    or7 = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      m7 = iv[7]; d7 = iv[6:0]; v7 = 1; n = 0;
      do begin
        @(negedge clk);
        acc = ir7;
        tick();
        n++;
      end while (!acc && n < 20);
    end
    v7 = 0;
    repeat (4) tick();
    chk("w7_drained", exp7.size(), 0);
    chk("w7_out_count", n_out7, 256);

    // Reset mid-operation with two beats in flight
    q8.delete(); t8.delete();
    or8 = 0;
    send8(1'b0, 8'h33);
    send8(1'b1, 8'h44);
    v8 = 0;
    tick();
    chk("mid_full", ov8, 1);
    chk("mid_full_rdy", ir8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", ov8, 0);
    chk("mid_out_data", od8, 0);
    chk("mid_out_mode", om8, 0);
    chk("mid_in_ready", ir8, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    or8 = 1;
    repeat (5) tick();
    chk("mid_no_stale", q8.size(), 0);

    // Random stress on WIDTH=16
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        v16 = ($urandom_range(0, 3) != 0);
        m16 = 1'($urandom_range(0, 1));
        d16 = 16'($urandom);
      end
      or16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = v16 && !ir16;
      tick();
    end
    v16 = 0; or16 = 1;
    repeat (5) tick();
    chk("w16_drained", exp16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
